// File: rtl/video_timing_gen_pkg.sv
// Shared definitions for the video timing generator: pattern encodings,
// colour-bar constants and the 1280x720p60 default timing.
// No logic; imported by video_timing_gen and video_pattern_gen.
package video_timing_gen_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pat_sel_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FP     = 110;
  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BP     = 220;
  localparam int unsigned DEF_V_ACTIVE = 720;
  localparam int unsigned DEF_V_FP     = 5;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 20;

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Test-pattern pixel source: bars, grey ramp, solid colour or checkerboard.
// Latency: purely combinational, no clock.
// Backpressure: none; the pixel for the current counter state is always valid.
// Ports: h_cnt/v_cnt raster position, pat_sel pattern, color solid colour,
//        rgb pixel {R,G,B} (not blanked; the caller gates it with data enable).
module video_pattern_gen
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_W      = 11,
  parameter int unsigned V_W      = 10
) (
  input  logic [H_W-1:0] h_cnt,
  input  logic [V_W-1:0] v_cnt,
  input  pat_sel_e       pat_sel,
  input  logic [23:0]    color,
  output logic [23:0]    rgb
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;
  // Bit-5 masks; they collapse to zero when a counter is narrower than 6 bits.
  localparam logic [H_W-1:0] H_BIT5 = H_W'(32);
  localparam logic [V_W-1:0] V_BIT5 = V_W'(32);

  logic [2:0] bar_idx;
  logic [7:0] ramp;
  logic       chk;

  // Threshold search instead of a divide: BAR_W need not be a power of two.
  always_comb begin
    bar_idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (32'(h_cnt) < BAR_W * (i + 1)) bar_idx = 3'(i);
    end
  end

  assign ramp = 8'(h_cnt);
  assign chk  = (|(h_cnt & H_BIT5)) ^ (|(v_cnt & V_BIT5));

  always_comb begin
    rgb = RGB_BLACK;
    case (pat_sel)
      PAT_BARS:  rgb = bar_color(bar_idx);
      PAT_RAMP:  rgb = {ramp, ramp, ramp};
      PAT_SOLID: rgb = color;
      PAT_CHECK: rgb = chk ? RGB_WHITE : RGB_BLACK;
      default:   rgb = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with built-in test patterns (HS/VS/DE/RGB).
// Latency: outputs registered one clock after the counter state they decode.
// Backpressure: none; free-running while I_en is high, idle and blanked otherwise.
// Ports: I_clk pixel clock, I_rst_n async active-low reset, I_en run enable,
//        I_pat_sel pattern (taken at frame start), I_color solid colour,
//        O_vs/O_hs syncs, O_de data enable, O_rgb pixel {R,G,B}.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_en,
  input  logic [1:0]  I_pat_sel,
  input  logic [23:0] I_color,
  output logic        O_vs,
  output logic        O_hs,
  output logic        O_de,
  output logic [23:0] O_rgb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic [31:0]    h32;
  logic [31:0]    v32;
  logic           en_q;
  pat_sel_e       pat_sel_q;
  pat_sel_e       pat_sel_cur;
  logic           frame_start;
  logic           h_last;
  logic           v_last;
  logic           de_int;
  logic           hs_int;
  logic           vs_int;
  logic [23:0]    pat_rgb;

  assign h32         = 32'(h_cnt);
  assign v32         = 32'(v_cnt);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign h_last      = (h32 == H_TOTAL - 1);
  assign v_last      = (v32 == V_TOTAL - 1);

  assign de_int = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
  assign hs_int = (h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC);
  assign vs_int = (v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC);

  // en_q marks that the counters hold live raster state. The first clock with
  // I_en high only arms it, so the frame starts with the counters at 0,0 and
  // reset release and re-enable follow the same two-edge startup.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q <= I_en;
      if (!I_en) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (en_q) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // The frame-start pixel must already use the newly selected pattern, so the
  // value being loaded is forwarded to the pattern source on that clock.
  assign pat_sel_cur = frame_start ? pat_sel_e'(I_pat_sel) : pat_sel_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pat_sel_q <= PAT_BARS;
    end else if (frame_start) begin
      pat_sel_q <= pat_sel_e'(I_pat_sel);
    end
  end

  video_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_W      (H_W),
    .V_W      (V_W)
  ) u_pattern (
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .pat_sel (pat_sel_cur),
    .color   (I_color),
    .rgb     (pat_rgb)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_de  <= 1'b0;
      O_rgb <= '0;
      O_hs  <= ~HS_POL;
      O_vs  <= ~VS_POL;
    end else if (!en_q) begin
      O_de  <= 1'b0;
      O_rgb <= '0;
      O_hs  <= ~HS_POL;
      O_vs  <= ~VS_POL;
    end else begin
      O_de  <= de_int;
      O_rgb <= de_int ? pat_rgb : 24'h0;
      O_hs  <= hs_int ? HS_POL : ~HS_POL;
      O_vs  <= vs_int ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a 16x8 raster (8x4 active).
// Reference: a run-length model -- the number of consecutive enabled clocks
// gives the raster position directly, and outputs follow from the timing rules.
module tb_video_timing_gen;

  localparam int HA = 8;
  localparam int HT = 16;
  localparam int VA = 4;
  localparam int VT = 8;
  localparam int FT = HT * VT;
  localparam int HS_START = HA + 2;
  localparam int HS_END   = HA + 2 + 2;
  localparam int VS_START = VA + 1;
  localparam int VS_END   = VA + 1 + 1;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic        I_en;
  logic [1:0]  I_pat_sel;
  logic [23:0] I_color;
  logic        O_vs;
  logic        O_hs;
  logic        O_de;
  logic [23:0] O_rgb;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          run_len = 0;
  int          mp = -1;
  logic [1:0]  frame_pat = 2'd0;
  logic        e_de, e_hs, e_vs;
  logic [23:0] e_rgb;

  // window statistics
  logic win = 1'b0;
  int   nsamp = 0;
  int   tot_de = 0, tot_hs = 0, tot_vs = 0;
  int   de_rise = -1000;
  logic prev_de = 1'b0, prev_hs = 1'b0;

  video_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (4),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (2),
    .HS_POL   (1'b1), .VS_POL (1'b1)
  ) dut (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .I_en      (I_en),
    .I_pat_sel (I_pat_sel),
    .I_color   (I_color),
    .O_vs      (O_vs),
    .O_hs      (O_hs),
    .O_de      (O_de),
    .O_rgb     (O_rgb)
  );

  always #5 I_clk = ~I_clk;

  function automatic logic [23:0] ref_pixel(input logic [1:0] pat, input int x, input int y,
                                            input logic [23:0] c);
    logic [7:0] g;
    g = 8'(x);
    case (pat)
      2'd0:    return BARS[x / (HA / 8)];
      2'd1:    return {g, g, g};
      2'd2:    return c;
      default: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int p, x, y;
    @(posedge I_clk);
    if (!I_rst_n) begin
      run_len = 0; mp = -1;
      e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_rgb = 24'h0;
    end else begin
      if (run_len == 0) begin
        mp = -1;
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_rgb = 24'h0;
      end else begin
        p = (run_len - 1) % FT;
        x = p % HT;
        y = p / HT;
        mp = p;
        if (p == 0) frame_pat = I_pat_sel;
        e_de  = (x < HA) && (y < VA);
        e_hs  = (x >= HS_START) && (x < HS_END);
        e_vs  = (y >= VS_START) && (y < VS_END);
        e_rgb = e_de ? ref_pixel(frame_pat, x, y, I_color) : 24'h0;
      end
      run_len = I_en ? run_len + 1 : 0;
    end
    #1;
    check("de",  {23'h0, O_de}, {23'h0, e_de});
    check("hs",  {23'h0, O_hs}, {23'h0, e_hs});
    check("vs",  {23'h0, O_vs}, {23'h0, e_vs});
    check("rgb", O_rgb, e_rgb);
    nsamp++;
    if (win) begin
      tot_de += int'(O_de);
      tot_hs += int'(O_hs);
      tot_vs += int'(O_vs);
      if (O_de && !prev_de) de_rise = nsamp;
      if (O_hs && !prev_hs && (nsamp - de_rise) < HT)
        check("hs_offset", 24'(nsamp - de_rise), 24'd10);
    end
    prev_de = O_de;
    prev_hs = O_hs;
  endtask

  // Step until the model reports raster position target; a miss is a failure.
  task automatic run_to(input int target, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      I_color = $urandom;
      if (mp == target) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $error("FAIL %s position never reached observed=%0d expected=%0d", tag, mp, target);
    end
  endtask

  initial begin
    I_rst_n = 1'b1; I_en = 1'b0; I_pat_sel = 2'd0; I_color = 24'h0;
    #1 I_rst_n = 1'b0;
    #1;
    check("rst_de",  {23'h0, O_de}, 24'h0);
    check("rst_rgb", O_rgb, 24'h0);
    check("rst_hs",  {23'h0, O_hs}, 24'h0);
    check("rst_vs",  {23'h0, O_vs}, 24'h0);
    step(); step();

    // release reset with enable high: first O_de on the second edge
    #2 I_rst_n = 1'b1; I_en = 1'b1; I_color = $urandom;
    step();
    check("start_edge1_de", {23'h0, O_de}, 24'h0);
    step();
    check("start_edge2_de", {23'h0, O_de}, 24'h1);
    check("bar_px0", O_rgb, BARS[0]);
    for (int i = 1; i < 8; i++) begin
      I_color = $urandom;
      step();
      check("bar_px", O_rgb, BARS[i]);
    end

    // three frames' worth of clocks
    win = 1'b1; tot_de = 0; tot_hs = 0; tot_vs = 0;
    for (int i = 0; i < 3 * FT; i++) begin
      I_color = $urandom;
      step();
    end
    win = 1'b0;
    check("de_total", 24'(tot_de), 24'd96);
    check("hs_total", 24'(tot_hs), 24'd48);
    check("vs_total", 24'(tot_vs), 24'd48);

    // pattern change mid-frame takes effect only at next frame start
    I_pat_sel = 2'd2;
    run_to(2 * HT, "bars_hold");
    I_color = 24'h123456;
    check("bars_hold", O_rgb, 24'hFFFFFF);
    for (int k = 0; k < 300 && mp != 0; k++) step();
    check("solid_first", O_rgb, 24'h123456);

    // grey ramp
    I_pat_sel = 2'd1;
    run_to(0, "ramp_start");
    check("ramp_px0", O_rgb, 24'h000000);
    for (int n = 1; n < 8; n++) begin
      logic [7:0] nb;
      nb = 8'(n);
      step();
      check("ramp_px", O_rgb, {nb, nb, nb});
    end

    // enable drop with counters at h=5, v=2
    run_to(2 * HT + 4, "en_drop");
    I_en = 1'b0;
    step();
    check("drop_last_px", O_rgb, 24'h050505);
    step();
    check("drop_de",  {23'h0, O_de}, 24'h0);
    check("drop_rgb", O_rgb, 24'h0);
    step();
    I_en = 1'b1;
    step();
    check("reen_edge1_de", {23'h0, O_de}, 24'h0);
    step();
    check("reen_edge2_de", {23'h0, O_de}, 24'h1);

    // asynchronous reset mid-line
    run_to(3, "async_rst");
    #2 I_rst_n = 1'b0;
    #1;
    check("arst_de",  {23'h0, O_de}, 24'h0);
    check("arst_rgb", O_rgb, 24'h0);
    check("arst_hs",  {23'h0, O_hs}, 24'h0);
    check("arst_vs",  {23'h0, O_vs}, 24'h0);
    step();
    #2 I_rst_n = 1'b1;
    step();
    step();
    check("arst_restart_de", {23'h0, O_de}, 24'h1);

    // randomized run: colours every clock, occasional pattern and enable changes
    for (int i = 0; i < 1200; i++) begin
      I_color = $urandom;
      if ($urandom_range(0, 63) == 0) I_pat_sel = 2'($urandom_range(0, 3));
      if (I_en && $urandom_range(0, 199) == 0) I_en = 1'b0;
      else if (!I_en && $urandom_range(0, 3) == 0) I_en = 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
